mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Requests are registered and arbitrated with data-over-fetch priority plus an anti-starvation cap. Each granted access runs on the memory's variable-latency req/ack handshake. A stall output lets the pipeline hold its stage registers while any access is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 3;
  localparam int STREAK_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory handshake bundle for the memory port arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Grant picker: data over fetch until the data streak cap is reached.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic                if_el_i,
  input  logic                d_el_i,
  input  logic [STREAK_W-1:0] d_streak_i,
  output gnt_e                gnt_o
);

  logic cap_hit;

  assign cap_hit = d_streak_i >= STREAK_W'(MAX_D_STREAK);

  always_comb begin
    gnt_o = GNT_NONE;
    unique case (1'b1)
      (if_el_i & d_el_i):  gnt_o = cap_hit ? GNT_IF : GNT_D;
      (if_el_i & ~d_el_i): gnt_o = GNT_IF;
      (~if_el_i & d_el_i): gnt_o = GNT_D;
      default:             gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               stall
);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rd_q, if_rd_d;
  logic [DATA_W-1:0]   d_rd_q, d_rd_d;
  logic                if_rdy_q, if_rdy_d;
  logic                d_rdy_q, d_rdy_d;
  logic                if_el, d_el;
  gnt_e                gnt;

  // A requester completing this cycle is not eligible again until next.
  assign if_el = bus.if_req & ~if_rdy_q;
  assign d_el  = bus.d_req & ~d_rdy_q;
  assign stall = if_el | d_el;

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .if_el_i   (if_el),
    .d_el_i    (d_el),
    .d_streak_i(streak_q),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_rd_d  = if_rd_q;
    d_rd_d   = d_rd_q;
    if_rdy_d = 1'b0;
    d_rdy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (gnt)
          GNT_IF: begin
            state_d  = BUSY_IF;
            req_d    = 1'b1;
            we_d     = 1'b0;
            addr_d   = bus.if_addr;
            wdata_d  = '0;
            streak_d = '0;
          end
          GNT_D: begin
            state_d = BUSY_D;
            req_d   = 1'b1;
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            if (!if_el)
              streak_d = '0;
            else if (streak_q < STREAK_W'(MAX_D_STREAK))
              streak_d = streak_q + 1'b1;
          end
          default: ;
        endcase
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (state_q == BUSY_IF) begin
            if_rd_d  = bus.mem_rdata;
            if_rdy_d = 1'b1;
          end else begin
            if (!we_q)
              d_rd_d = bus.mem_rdata;
            d_rdy_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      if_rdy_q <= 1'b0;
      d_rdy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      if_rd_q  <= if_rd_d;
      d_rd_q   <= d_rd_d;
      if_rdy_q <= if_rdy_d;
      d_rdy_q  <= d_rdy_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.if_ready  = if_rdy_q;
  assign bus.d_rdata   = d_rd_q;
  assign bus.d_ready   = d_rdy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, corner sequences, random traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall;
  int   total = 0;
  int   bad = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus),
    .stall(stall)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int lat = 0;
  int wait_n = 0;
  bit force_ack = 0;
  bit rand_lat = 0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory model: acks after lat waiting cycles, spurious acks on request.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_n = 0;
      end else if (!bus.mem_req) begin
        wait_n = 0;
        if (force_ack) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = 32'h5EED0A0C;
        end
      end else if (wait_n >= lat) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        else bus.mem_rdata = mem[bus.mem_addr[9:2]];
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        wait_n++;
      end
      force_ack = 1'b0;
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic clear_reqs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic run_vec(vec_t v, int idx);
    bit done = 0;
    int n = 0;
    logic rdy, oth;
    lat = v.lat;
    if (v.is_d) begin
      bus.d_req = 1; bus.d_we = v.we;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1; bus.if_addr = v.addr;
    end
    #1 chk($sformatf("v%0d stall_req", idx), stall, 1);
    for (int c = 1; c <= 20 && !done; c++) begin
      step();
      rdy = v.is_d ? bus.d_ready : bus.if_ready;
      oth = v.is_d ? bus.if_ready : bus.d_ready;
      if (oth) chk($sformatf("v%0d other_rdy", idx), oth, 0);
      if (c <= 1 + v.lat) begin
        chk($sformatf("v%0d mem_req", idx), bus.mem_req, 1);
        chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
        chk($sformatf("v%0d mem_we", idx), bus.mem_we, v.is_d & v.we);
        chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata,
            v.is_d ? v.wdata : 32'h0);
      end
      if (rdy) begin
        done = 1;
        n = c;
      end else begin
        chk($sformatf("v%0d stall_busy", idx), stall, 1);
      end
    end
    chk($sformatf("v%0d latency", idx), n, 2 + v.lat);
    chk($sformatf("v%0d rdata", idx),
        v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rd);
    chk($sformatf("v%0d stall_rdy", idx), stall, 0);
    chk($sformatf("v%0d req_drop", idx), bus.mem_req, 0);
    chk($sformatf("v%0d we_drop", idx), bus.mem_we, 0);
    clear_reqs();
    step();
    rdy = v.is_d ? bus.d_ready : bus.if_ready;
    chk($sformatf("v%0d one_pulse", idx), rdy, 0);
  endtask

  // Scoreboard over random traffic: grant choice, hold, completion data.
  task automatic rand_phase(int ncyc);
    int owner = 0;
    int streak = 0;
    bit own_we = 0;
    logic [31:0] own_addr = '0, own_wdata = '0;
    logic [31:0] e_if_rd = '0, e_d_rd = '0;
    logic [31:0] p_ack_data = '0;
    bit p_ack = 0, p_if_el = 0, p_d_el = 0;
    bit e_if_rdy, e_d_rdy, pick_d;
    for (int k = 0; k < ncyc; k++) begin
      step();
      e_if_rdy = p_ack && owner == 1;
      e_d_rdy  = p_ack && owner == 2;
      if (owner != 0 && p_ack) begin
        if (owner == 1) e_if_rd = p_ack_data;
        else if (!own_we) e_d_rd = p_ack_data;
        chk("r req_done", bus.mem_req, 0);
        owner = 0;
      end else if (owner != 0) begin
        chk("r req_hold", bus.mem_req, 1);
        chk("r addr_hold", bus.mem_addr, own_addr);
        chk("r we_hold", bus.mem_we, own_we);
        chk("r wdata_hold", bus.mem_wdata, own_wdata);
      end else if (p_if_el || p_d_el) begin
        pick_d = p_d_el && (!p_if_el || streak < MAXS);
        if (pick_d && p_if_el) streak = (streak < MAXS) ? streak + 1 : MAXS;
        else streak = 0;
        owner = pick_d ? 2 : 1;
        own_addr = pick_d ? bus.d_addr : bus.if_addr;
        own_we = pick_d ? bus.d_we : 1'b0;
        own_wdata = pick_d ? bus.d_wdata : 32'h0;
        chk("r grant_req", bus.mem_req, 1);
        chk("r grant_addr", bus.mem_addr, own_addr);
        chk("r grant_we", bus.mem_we, own_we);
        chk("r grant_wdata", bus.mem_wdata, own_wdata);
      end else begin
        chk("r idle_req", bus.mem_req, 0);
      end
      chk("r if_ready", bus.if_ready, e_if_rdy);
      chk("r d_ready", bus.d_ready, e_d_rdy);
      chk("r if_rdata", bus.if_rdata, e_if_rd);
      chk("r d_rdata", bus.d_rdata, e_d_rd);
      if (bus.if_req && e_if_rdy) begin
        if ($urandom_range(0, 1) == 1)
          bus.if_addr = 32'($urandom_range(0, 255)) << 2;
        else bus.if_req = 0;
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1;
        bus.if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (bus.d_req && e_d_rdy) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.d_addr = 32'($urandom_range(0, 255)) << 2;
          bus.d_we = 1'($urandom_range(0, 1));
          bus.d_wdata = $urandom;
        end else bus.d_req = 0;
      end else if (!bus.d_req && $urandom_range(0, 1) == 0) begin
        bus.d_req = 1;
        bus.d_addr = 32'($urandom_range(0, 255)) << 2;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_wdata = $urandom;
      end
      if (!bus.mem_req && $urandom_range(0, 9) == 0) force_ack = 1;
      #1;
      chk("r stall", stall, (bus.if_req & ~e_if_rdy) | (bus.d_req & ~e_d_rdy));
      p_ack = bus.mem_ack;
      p_ack_data = bus.mem_rdata;
      p_if_el = bus.if_req & ~e_if_rdy;
      p_d_el = bus.d_req & ~e_d_rdy;
    end
  endtask

  vec_t vecs[5];
  logic [31:0] snap_a, snap_i, snap_d;
  bit hit;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h01010101) ^ 32'hC3C30000;
    mem[16]  = 32'h8C010004;
    mem[64]  = 32'h11112222;
    mem[255] = 32'h0BADF00D;
    vecs[0] = '{0, 0, 32'h040, 32'h0,        2, 32'h8C010004};
    vecs[1] = '{1, 0, 32'h100, 32'h0,        0, 32'h11112222};
    vecs[2] = '{1, 1, 32'h200, 32'hDEADBEEF, 1, 32'h11112222};
    vecs[3] = '{1, 0, 32'h200, 32'h0,        3, 32'hDEADBEEF};
    vecs[4] = '{0, 0, 32'h3FC, 32'h0,        0, 32'h0BADF00D};
    clear_reqs();
    rst_n = 0;
    repeat (3) step();
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst mem_we", bus.mem_we, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst if_rdata", bus.if_rdata, 0);
    chk("rst d_rdata", bus.d_rdata, 0);
    chk("rst if_ready", bus.if_ready, 0);
    chk("rst d_ready", bus.d_ready, 0);
    chk("rst stall", stall, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data first, then fetch, D not regranted.
    lat = 0;
    bus.if_req = 1; bus.if_addr = 32'h080;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    step();
    chk("sim first_addr", bus.mem_addr, 32'h100);
    chk("sim first_we", bus.mem_we, 0);
    step();
    chk("sim d_ready", bus.d_ready, 1);
    chk("sim d_rdata", bus.d_rdata, mem[64]);
    bus.d_addr = 32'h104;
    step();
    chk("sim if_grant_req", bus.mem_req, 1);
    chk("sim if_grant_addr", bus.mem_addr, 32'h080);
    step();
    chk("sim if_ready", bus.if_ready, 1);
    chk("sim if_rdata", bus.if_rdata, mem[32]);
    bus.if_req = 0;
    step();
    chk("sim d2_addr", bus.mem_addr, 32'h104);
    step();
    chk("sim d2_ready", bus.d_ready, 1);
    chk("sim d2_rdata", bus.d_rdata, mem[65]);
    clear_reqs();
    step();

    // Reset asserted while a data read is outstanding.
    lat = 10;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    repeat (3) step();
    chk("rmid busy", bus.mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rmid req_drop", bus.mem_req, 0);
    chk("rmid no_ready", bus.d_ready, 0);
    lat = 1;
    step();
    chk("rmid held_ready", bus.d_ready, 0);
    rst_n = 1;
    chk("rmid idle", bus.mem_req, 0);
    hit = 0; n = 0;
    for (int c = 1; c <= 10 && !hit; c++) begin
      step();
      if (c == 1) chk("rmid regrant", bus.mem_addr, 32'h100);
      if (bus.d_ready) begin hit = 1; n = c; end
    end
    chk("rmid latency", n, 3);
    chk("rmid rdata", bus.d_rdata, mem[64]);
    clear_reqs();
    step();

    // Spurious ack while idle.
    step();
    snap_a = bus.mem_addr; snap_i = bus.if_rdata; snap_d = bus.d_rdata;
    force_ack = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("spur req", bus.mem_req, 0);
      chk("spur if_ready", bus.if_ready, 0);
      chk("spur d_ready", bus.d_ready, 0);
      chk("spur addr", bus.mem_addr, snap_a);
      chk("spur if_rdata", bus.if_rdata, snap_i);
      chk("spur d_rdata", bus.d_rdata, snap_d);
      chk("spur stall", stall, 0);
    end

    // Random traffic from a clean reset.
    rst_n = 0;
    step();
    rst_n = 1;
    lat = 1;
    rand_lat = 1;
    step();
    rand_phase(3000);
    clear_reqs();
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
